// File: rtl/ieeedrv_pkg.sv
// Shared types for the IEEE drive SD-host arbitration logic.
package ieeedrv_pkg;

  localparam int unsigned LBA_W = 32;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned DAT_W = 8;

  typedef struct packed {
    logic [LBA_W-1:0] lba;
    logic [CNT_W-1:0] blk_cnt;
    logic             rd;
    logic             wr;
  } sd_req_t;

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    ISSUE,
    XFER,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/ieeedrv_sd_arb_if.sv
// Requester-side and host-side signals of the shared SD channel arbiter.
interface ieeedrv_sd_arb_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned GW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  import ieeedrv_pkg::*;

  logic [NREQ-1:0][LBA_W-1:0] req_lba;
  logic [NREQ-1:0][CNT_W-1:0] req_blk_cnt;
  logic [NREQ-1:0]            req_rd;
  logic [NREQ-1:0]            req_wr;
  logic [NREQ-1:0]            req_ack;
  logic [NREQ-1:0][DAT_W-1:0] req_buff_din;
  logic [NREQ-1:0]            req_err;
  logic [LBA_W-1:0]           sd_lba;
  logic [CNT_W-1:0]           sd_blk_cnt;
  logic                       sd_rd;
  logic                       sd_wr;
  logic                       sd_ack;
  logic [DAT_W-1:0]           sd_buff_din;
  logic [GW-1:0]              grant;
  logic                       active;

  modport master (
    input  req_lba, req_blk_cnt, req_rd, req_wr, req_buff_din, sd_ack,
    output req_ack, req_err, sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
           grant, active
  );

  modport slave (
    output req_lba, req_blk_cnt, req_rd, req_wr, req_buff_din, sd_ack,
    input  req_ack, req_err, sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
           grant, active
  );

endinterface

// File: rtl/ieeedrv_rr_pick.sv
// Combinational round-robin picker: first pending index at or after ptr, wrapping.
module ieeedrv_rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] pending,
  input  logic [GW-1:0]   ptr,
  output logic            valid,
  output logic [GW-1:0]   idx
);

  int unsigned   cand;
  logic [GW-1:0] cand_idx;

  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = GW'(cand);
      if (!valid && pending[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ieeedrv_sd_arb.sv
// Round-robin arbiter sharing one SD host port between NREQ drive requesters,
// with an ack watchdog that drops and masks a requester the host never answers.
module ieeedrv_sd_arb
  import ieeedrv_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned TMO_W = 20
) (
  input  logic             clk_sys,
  input  logic             reset,
  ieeedrv_sd_arb_if.master bus
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t       state_q, state_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [GW-1:0]    grant_q, grant_d;
  sd_req_t          req_q, req_d;
  logic             active_q, active_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [NREQ-1:0]  mask_q, mask_d;
  logic [NREQ-1:0]  err_q, err_d;

  logic [NREQ-1:0]  raw_c;
  logic [NREQ-1:0]  pend_c;
  logic             pick_valid_c;
  logic [GW-1:0]    pick_idx_c;
  logic [GW-1:0]    grant_nxt_c;

  assign raw_c  = bus.req_rd | bus.req_wr;
  assign pend_c = raw_c & ~mask_q;

  ieeedrv_rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .pending (pend_c),
    .ptr     (ptr_q),
    .valid   (pick_valid_c),
    .idx     (pick_idx_c)
  );

  // Explicit wrap so non-power-of-two NREQ never lands on an empty index.
  assign grant_nxt_c = (32'(grant_q) == NREQ - 1) ? '0 : grant_q + GW'(1);

  // Next-state and next-register logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    req_d    = req_q;
    active_d = active_q;
    tmo_d    = tmo_q;
    err_d    = '0;
    mask_d   = mask_q & raw_c;

    unique case (state_q)
      DRAIN: begin
        if (!bus.sd_ack) state_d = IDLE;
      end
      IDLE: begin
        if (pick_valid_c) begin
          grant_d       = pick_idx_c;
          req_d.lba     = bus.req_lba[pick_idx_c];
          req_d.blk_cnt = bus.req_blk_cnt[pick_idx_c];
          req_d.rd      = bus.req_rd[pick_idx_c];
          req_d.wr      = !bus.req_rd[pick_idx_c];
          active_d      = 1'b1;
          tmo_d         = '0;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (bus.sd_ack) begin
          req_d.rd = 1'b0;
          req_d.wr = 1'b0;
          state_d  = XFER;
        end else if (&tmo_d) begin
          req_d.rd         = 1'b0;
          req_d.wr         = 1'b0;
          active_d         = 1'b0;
          err_d[grant_q]   = 1'b1;
          mask_d[grant_q]  = 1'b1;
          ptr_d            = grant_nxt_c;
          state_d          = IDLE;
        end
      end
      XFER: begin
        if (!bus.sd_ack) begin
          active_d = 1'b0;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        ptr_d   = grant_nxt_c;
        state_d = IDLE;
      end
      default: state_d = DRAIN;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= DRAIN;
      ptr_q    <= '0;
      grant_q  <= '0;
      req_q    <= '0;
      active_q <= 1'b0;
      tmo_q    <= '0;
      mask_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      req_q    <= req_d;
      active_q <= active_d;
      tmo_q    <= tmo_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
    end
  end

  assign bus.sd_lba     = req_q.lba;
  assign bus.sd_blk_cnt = req_q.blk_cnt;
  assign bus.sd_rd      = req_q.rd;
  assign bus.sd_wr      = req_q.wr;
  assign bus.grant      = grant_q;
  assign bus.active     = active_q;
  assign bus.req_err    = err_q;

  // Ack and write data follow the grant only while a transaction is open.
  always_comb begin
    bus.req_ack     = '0;
    bus.sd_buff_din = '0;
    if (active_q) begin
      bus.req_ack[grant_q] = bus.sd_ack;
      bus.sd_buff_din      = bus.req_buff_din[grant_q];
    end
  end

endmodule
